// File: rtl/dma_multichannel.sv
// N-channel byte-copy DMA between a CPU page and a fixed device register; channel 0 can alias the $4014 OAM DMA.
// Stall rises the cycle after the trigger write; a transfer of len bytes holds the CPU 2*len+1 cycles (+1 on odd start).
module dma_multichannel #(
  parameter int          CHANNELS  = 2,
  parameter logic [15:0] CTRL_BASE = 16'h4020,
  parameter bit          LEGACY_EN = 1'b1,
  parameter bit          ODD_ALIGN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         address_in,
  input  logic                cpu_write,
  input  logic [7:0]          data_in,
  output logic [15:0]         address_out,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic                mem_rd,
  output logic                dev_wr,
  output logic                cpu_stall,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam int          CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [15:0] LEGACY_ADDR = 16'h4014;
  localparam logic [15:0] LEGACY_DEST = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ALIGN2,
    S_READ,
    S_WRITE
  } state_t;

  state_t state;

  logic [7:0] dest_lo  [CHANNELS];
  logic [7:0] dest_hi  [CHANNELS];
  logic [7:0] len      [CHANNELS];
  logic [7:0] src_page [CHANNELS];

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] pending_nxt;
  logic [CHANNELS-1:0] reg_hit;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] sel_oh;
  logic [CW-1:0]       sel;
  logic [CW-1:0]       cur;
  logic                start;
  logic                legacy_hit;
  logic [15:0]         off;
  logic                parity;
  logic                odd_start;
  logic [7:0]          idx;
  logic [7:0]          last_idx;
  logic [15:0]         cur_dest;
  logic [15:0]         dma_addr;

  // Register window decode; a channel that is currently running ignores all of its register writes.
  always_comb begin
    off        = address_in - CTRL_BASE;
    legacy_hit = LEGACY_EN && cpu_write && (address_in == LEGACY_ADDR) && !busy[0];
    reg_hit    = '0;
    trig       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      reg_hit[k] = cpu_write && (off[15:2] == 14'(k)) && !busy[k];
      trig[k]    = reg_hit[k] && (off[1:0] == 2'd3);
    end
    if (legacy_hit) trig[0] = 1'b1;
  end

  // A trigger arriving while idle is arbitrated in the same cycle, so the write cycle doubles as the decision cycle.
  always_comb begin
    req    = pending | trig;
    sel    = '0;
    sel_oh = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (req[k]) begin
        sel       = CW'(k);
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
      end
    end
    start       = (state == S_IDLE) && (|req);
    pending_nxt = start ? (req & ~sel_oh) : req;
  end

  assign last_idx    = len[cur] - 8'd1;
  assign cur_dest    = {dest_hi[cur], dest_lo[cur]};
  assign address_out = (mem_rd || dev_wr) ? dma_addr : address_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        dest_lo[k]  <= '0;
        dest_hi[k]  <= '0;
        len[k]      <= '0;
        src_page[k] <= '0;
      end
    end else begin
      if (legacy_hit) begin
        dest_lo[0]  <= LEGACY_DEST[7:0];
        dest_hi[0]  <= LEGACY_DEST[15:8];
        len[0]      <= 8'd0;
        src_page[0] <= data_in;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (reg_hit[k]) begin
          case (off[1:0])
            2'd0:    dest_lo[k]  <= data_in;
            2'd1:    dest_hi[k]  <= data_in;
            2'd2:    len[k]      <= data_in;
            default: src_page[k] <= data_in;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      parity    <= 1'b0;
      odd_start <= 1'b0;
      cur       <= '0;
      idx       <= '0;
      dma_addr  <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      mem_rd    <= 1'b0;
      dev_wr    <= 1'b0;
      cpu_stall <= 1'b0;
      busy      <= '0;
      done      <= '0;
    end else begin
      parity  <= ~parity;
      pending <= pending_nxt;
      done    <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ALIGN;
            cur       <= sel;
            busy      <= sel_oh;
            idx       <= 8'd0;
            odd_start <= parity;
            cpu_stall <= 1'b1;
          end else begin
            cpu_stall <= 1'b0;
          end
        end
        S_ALIGN: begin
          if (ODD_ALIGN && odd_start) begin
            state <= S_ALIGN2;
          end else begin
            state    <= S_READ;
            mem_rd   <= 1'b1;
            dma_addr <= {src_page[cur], idx};
          end
        end
        S_ALIGN2: begin
          state    <= S_READ;
          mem_rd   <= 1'b1;
          dma_addr <= {src_page[cur], idx};
        end
        S_READ: begin
          state    <= S_WRITE;
          mem_rd   <= 1'b0;
          dev_wr   <= 1'b1;
          data_oe  <= 1'b1;
          data_out <= data_in;
          dma_addr <= cur_dest;
        end
        S_WRITE: begin
          dev_wr   <= 1'b0;
          data_oe  <= 1'b0;
          data_out <= '0;
          if (idx == last_idx) begin
            state     <= S_IDLE;
            busy      <= '0;
            done      <= busy;
            // Keep the CPU held through the decision cycle when another channel is already queued.
            cpu_stall <= |pending_nxt;
          end else begin
            state    <= S_READ;
            idx      <= idx + 8'd1;
            mem_rd   <= 1'b1;
            dma_addr <= {src_page[cur], idx + 8'd1};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
